// File: rtl/ppu_arb_pkg.sv
// Shared types and defaults for the PPU VRAM bus arbiter.
package ppu_arb_pkg;

  localparam int DEF_AW           = 14;
  localparam int DEF_CPU_MAX_WAIT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    REQ_BG  = 2'd0,
    REQ_SPR = 2'd1,
    REQ_CPU = 2'd2
  } req_id_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ppu_arb_priority.sv
// Combinational requester picker: mode-dependent priority with a CPU aging override.
module ppu_arb_priority
  import ppu_arb_pkg::*;
(
  input  logic    bg_req,
  input  logic    spr_req,
  input  logic    cpu_req,
  input  logic    rendering,
  input  logic    age_hit,
  output req_id_t winner,
  output logic    valid
);

  // Pick one requester; an aged-out CPU beats rendering fetches
  always_comb begin
    winner = REQ_BG;
    valid  = 1'b0;
    if (rendering) begin
      if (cpu_req && age_hit) begin
        winner = REQ_CPU;
        valid  = 1'b1;
      end else if (bg_req) begin
        winner = REQ_BG;
        valid  = 1'b1;
      end else if (spr_req) begin
        winner = REQ_SPR;
        valid  = 1'b1;
      end else if (cpu_req) begin
        winner = REQ_CPU;
        valid  = 1'b1;
      end else begin
        winner = REQ_BG;
        valid  = 1'b0;
      end
    end else begin
      if (cpu_req) begin
        winner = REQ_CPU;
        valid  = 1'b1;
      end else if (bg_req) begin
        winner = REQ_BG;
        valid  = 1'b1;
      end else if (spr_req) begin
        winner = REQ_SPR;
        valid  = 1'b1;
      end else begin
        winner = REQ_BG;
        valid  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ppu_vram_arbiter.sv
// PPU VRAM/CHR bus arbiter: 2-cycle ALE/data accesses for BG, sprite and CPU requesters.
// Optional grant statistics are built when PPU_ARB_STATS_EN is defined.
module ppu_vram_arbiter
  import ppu_arb_pkg::*;
#(
  parameter int CPU_MAX_WAIT = DEF_CPU_MAX_WAIT,
  parameter int AW           = DEF_AW
) (
  input  logic          PPU_SLOW_CLOCK,
  input  logic          RST,
  input  logic          RENDERING,
  input  logic          BG_REQ,
  input  logic [AW-1:0] BG_ADDR,
  output logic          BG_GNT,
  output logic          BG_RVALID,
  input  logic          SPR_REQ,
  input  logic [AW-1:0] SPR_ADDR,
  output logic          SPR_GNT,
  output logic          SPR_RVALID,
  input  logic          CPU_REQ,
  input  logic          CPU_WE,
  input  logic [AW-1:0] CPU_ADDR,
  input  logic [7:0]    CPU_WDATA,
  output logic          CPU_GNT,
  output logic          CPU_RVALID,
  output logic [7:0]    RDATA,
  output logic [AW-1:0] APPU,
  output logic          ALE,
  output logic          PPU_WR,
  output logic [7:0]    PPUDO,
  input  logic [7:0]    PPUDI
`ifdef PPU_ARB_STATS_EN
  ,
  output logic [15:0]   STAT_BG,
  output logic [15:0]   STAT_SPR,
  output logic [15:0]   STAT_CPU,
  output logic [3:0]    STAT_CPU_MAXAGE
`endif
);

  localparam int AGE_W = $clog2(CPU_MAX_WAIT + 1);

  arb_state_t      state_r;
  req_id_t         owner_r;
  logic            owner_we_r;
  logic [7:0]      wdata_r;
  logic [AGE_W-1:0] age_r;

  req_id_t         win_id_s;
  logic            win_valid_s;
  logic            age_hit_s;
  logic            start_s;
  logic [AW-1:0]   win_addr_s;
  logic            win_we_s;
  logic [7:0]      win_wdata_s;

  assign age_hit_s = (age_r >= AGE_W'(CPU_MAX_WAIT));
  // A new access may only start while the bus is idle or finishing its data cycle
  assign start_s   = win_valid_s && ((state_r == IDLE) || (state_r == DATA));

  ppu_arb_priority u_pick (
    .bg_req    (BG_REQ),
    .spr_req   (SPR_REQ),
    .cpu_req   (CPU_REQ),
    .rendering (RENDERING),
    .age_hit   (age_hit_s),
    .winner    (win_id_s),
    .valid     (win_valid_s)
  );

  // Select the winning requester's address and write attributes
  always_comb begin
    win_addr_s  = BG_ADDR;
    win_we_s    = 1'b0;
    win_wdata_s = 8'h00;
    case (win_id_s)
      REQ_BG: begin
        win_addr_s  = BG_ADDR;
        win_we_s    = 1'b0;
        win_wdata_s = 8'h00;
      end
      REQ_SPR: begin
        win_addr_s  = SPR_ADDR;
        win_we_s    = 1'b0;
        win_wdata_s = 8'h00;
      end
      REQ_CPU: begin
        win_addr_s  = CPU_ADDR;
        win_we_s    = CPU_WE;
        win_wdata_s = CPU_WDATA;
      end
      default: begin
        win_addr_s  = BG_ADDR;
        win_we_s    = 1'b0;
        win_wdata_s = 8'h00;
      end
    endcase
  end

  // Access sequencer: ALE cycle, data cycle, then read-data return
  always_ff @(posedge PPU_SLOW_CLOCK) begin
    if (RST) begin
      state_r    <= IDLE;
      owner_r    <= REQ_BG;
      owner_we_r <= 1'b0;
      wdata_r    <= 8'h00;
      APPU       <= '0;
      ALE        <= 1'b0;
      PPU_WR     <= 1'b0;
      PPUDO      <= 8'h00;
      RDATA      <= 8'h00;
      BG_GNT     <= 1'b0;
      SPR_GNT    <= 1'b0;
      CPU_GNT    <= 1'b0;
      BG_RVALID  <= 1'b0;
      SPR_RVALID <= 1'b0;
      CPU_RVALID <= 1'b0;
    end else begin
      ALE        <= 1'b0;
      PPU_WR     <= 1'b0;
      BG_GNT     <= 1'b0;
      SPR_GNT    <= 1'b0;
      CPU_GNT    <= 1'b0;
      BG_RVALID  <= 1'b0;
      SPR_RVALID <= 1'b0;
      CPU_RVALID <= 1'b0;
      case (state_r)
        ADDR: begin
          state_r <= DATA;
          if (owner_we_r) begin
            PPU_WR <= 1'b1;
            PPUDO  <= wdata_r;
          end
        end
        IDLE, DATA: begin
          if ((state_r == DATA) && !owner_we_r) begin
            RDATA      <= PPUDI;
            BG_RVALID  <= (owner_r == REQ_BG);
            SPR_RVALID <= (owner_r == REQ_SPR);
            CPU_RVALID <= (owner_r == REQ_CPU);
          end
          if (start_s) begin
            state_r    <= ADDR;
            owner_r    <= win_id_s;
            owner_we_r <= win_we_s;
            wdata_r    <= win_wdata_s;
            APPU       <= win_addr_s;
            ALE        <= 1'b1;
            BG_GNT     <= (win_id_s == REQ_BG);
            SPR_GNT    <= (win_id_s == REQ_SPR);
            CPU_GNT    <= (win_id_s == REQ_CPU);
          end else begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // CPU aging: count arbitrations lost while the CPU keeps asking
  always_ff @(posedge PPU_SLOW_CLOCK) begin
    if (RST) begin
      age_r <= '0;
    end else if (!CPU_REQ) begin
      age_r <= '0;
    end else if (start_s && (win_id_s == REQ_CPU)) begin
      age_r <= '0;
    end else if (start_s && (age_r < AGE_W'(CPU_MAX_WAIT))) begin
      age_r <= age_r + AGE_W'(1);
    end
  end

`ifdef PPU_ARB_STATS_EN
  logic [3:0] age_clip_s;
  assign age_clip_s = (32'(age_r) > 32'd15) ? 4'd15 : 4'(age_r);

  // Saturating grant counters and peak CPU age
  always_ff @(posedge PPU_SLOW_CLOCK) begin
    if (RST) begin
      STAT_BG         <= 16'd0;
      STAT_SPR        <= 16'd0;
      STAT_CPU        <= 16'd0;
      STAT_CPU_MAXAGE <= 4'd0;
    end else begin
      if (start_s && (win_id_s == REQ_BG))  STAT_BG  <= sat_inc16(STAT_BG);
      if (start_s && (win_id_s == REQ_SPR)) STAT_SPR <= sat_inc16(STAT_SPR);
      if (start_s && (win_id_s == REQ_CPU)) STAT_CPU <= sat_inc16(STAT_CPU);
      if (age_clip_s > STAT_CPU_MAXAGE)     STAT_CPU_MAXAGE <= age_clip_s;
    end
  end
`endif

endmodule
